ppg_calib_ctrl: RTL and testbench
=================================

# ppg_calib_ctrl

Parametrised multi-channel calibration and sequencing controller for the photoplethysmography front end. On request it calibrates, per LED channel in turn, the DC-compensation DAC code and the PGA gain from windowed ADC min/max statistics. It then time-multiplexes the channels round-robin, applying each channel's stored settings and publishing one ADC sample per slot. It sits between the ADC capture and the LED driver, DC-DAC and PGA control pins.

## Interface
Parameters:
- N_CH, 2, number of LED channels; must be 2..8
- ADC_W, 8, ADC sample width
- DC_W, 7, DC-compensation code width
- PGA_W, 4, PGA gain code width
- WIN_LEN, 1000, valid samples per measurement window
- DC_INIT, 110, DC code loaded at the start of each channel
- PGA_INIT, 7, gain loaded at the start of each PGA search
- DC_LO / DC_HI, 120 / 135, accepted band for the window midpoint
- CLIP_LO / CLIP_HI, 10 / 245, clipping limits
- SLOT_LEN, 10, run-mode cycles per channel slot
- SETTLE, 16, samples discarded after a setting change (only with the macro)

Ports:
- CLK, in, 1, sole clock; all logic on the rising edge
- rst, in, 1, synchronous reset, active-high
- adc, in, ADC_W, ADC sample
- adc_valid, in, 1, qualifies adc; only qualified samples count
- find_setting, in, 1, level; high for one or more cycles (re)starts calibration
- led_en, out, N_CH, one-hot LED enable, or all zero
- dc_comp, out, DC_W, DC-DAC code
- pga_gain, out, PGA_W, PGA gain code
- busy, out, 1, calibration in progress
- done, out, 1, high in RUN
- fail, out, N_CH, per-channel sticky flag: DC code saturated or gain floor still clipped
- ch_value, out, N_CH*ADC_W, last run-mode sample per channel; channel k in bits [k*ADC_W +: ADC_W]
- ch_valid, out, 1, one-cycle pulse when ch_value is updated
- ch_idx, out, $clog2(N_CH), channel of the current ch_valid

## Operation
- Window: a running min/max over WIN_LEN valid samples. At window end the midpoint is (max+min)>>1, computed at ADC_W+1 bits. `clip` is asserted when min<=CLIP_LO or max>=CLIP_HI. Stats are cleared at the start of every window.
- States: IDLE, DC_CAL, PGA_DIR, PGA_UP, PGA_DOWN, NEXT_CH, RUN.
- IDLE: all LEDs off. find_setting moves to DC_CAL with ch=0, dc=DC_INIT and pga=0.
- DC_CAL: led_en=1<<ch.
  - Midpoint below DC_LO: dc-1.
  - Midpoint above DC_HI: dc+1.
  - Otherwise store dc[ch], load pga=PGA_INIT and go to PGA_DIR.
  - If a step would wrap dc below 0 or above its maximum: set fail[ch], store the current dc, go to PGA_DIR.
- PGA_DIR: no clip → pga+1 and go to PGA_UP. Clip → pga-1 and go to PGA_DOWN.
- PGA_UP: clip → store pga-1. No clip at max gain → store max. Otherwise pga+1.
- PGA_DOWN: no clip → store pga. Clip at gain 0 → store 0 and set fail[ch]. Otherwise pga-1.
- A stored gain moves to NEXT_CH.
- NEXT_CH: ch+1, dc=DC_INIT, go to DC_CAL. After the last channel, go to RUN with slot channel 0.
- RUN: each slot drives led_en, dc and pga from the channel's stored values. On the last cycle of the slot, if adc_valid, adc is written to ch_value[slot] with a ch_valid pulse. The slot counter advances modulo N_CH.
- find_setting in any non-IDLE state restarts calibration at channel 0 on the next cycle, clears fail and aborts the current window. find_setting takes priority over every transition.

## Timing
- Reset values: led_en=0, dc_comp=DC_INIT, pga_gain=0, busy=0, done=0, fail=0, ch_value=0, ch_valid=0, ch_idx=0, state IDLE.
- All outputs are registered. A setting change is visible on the cycle after the window-end sample.
- A window closes on the WIN_LEN-th valid sample. The decision takes one cycle, and the next window counts from the following valid sample.
- busy is high from the cycle after find_setting until RUN entry. done rises in the same cycle busy falls.
- The RUN slot is exactly SLOT_LEN cycles and independent of adc_valid. ch_valid is at most one per slot.

## Configuration
- PPG_CALIB_SETTLE_EN defined:
  - After any change to led_en, dc_comp or pga_gain during calibration, the next SETTLE valid samples are discarded before the window starts counting.
  - In RUN, sampling is suppressed if SLOT_LEN<=SETTLE.
- PPG_CALIB_SETTLE_EN undefined: no discard; the window starts on the next valid sample and the SETTLE parameter is ignored.

## Structure
- Package ppg_calib_pkg: state enum; default threshold constants DC_LO, DC_HI, CLIP_LO, CLIP_HI, DC_INIT, PGA_INIT.
- Sub-module ppg_window_stats:
  - Valid-qualified sample counter with WIN_LEN terminal count.
  - Min/max registers, optional settle counter.
  - Outputs win_done pulse, midpoint and clip.
- Top level holds the FSM, per-channel dc/pga storage arrays and the RUN slot timer.

## Test plan
- N_CH=2, adc midpoint stuck at 100 → dc decrements once per window from 110 until the modelled midpoint enters 120..135; stored dc matches the model.
- Swing fits at gain 7 and clips first at gain 10 → stored pga=9 via PGA_UP; clipping already at gain 7 and clean at 5 → stored pga=5 via PGA_DOWN.
- Midpoint forced to 0 at every dc → dc reaches 0, fail[0]=1, calibration continues to channel 1, done=1.
- In RUN with N_CH=3, SLOT_LEN=10, adc_valid=1 → ch_valid every 10 cycles with ch_idx 0,1,2,0 and led_en one-hot matching; each channel applies its own stored dc/pga.
- find_setting pulsed mid PGA_UP on channel 1 → next cycle: DC_CAL, ch=0, dc=110, fail cleared, busy=1.
- rst asserted mid-window → next cycle all outputs at reset values; PPG_CALIB_SETTLE_EN on vs off → first counted sample offset by SETTLE.

Source files
------------

// File: rtl/ppg_calib_ctrl_pkg.sv
// ============================================================================
// Module      : ppg_calib_pkg
// Description : Shared types and default thresholds for the PPG calibration
//               and sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ppg_calib_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DC_CAL   = 3'd1,
        ST_PGA_DIR  = 3'd2,
        ST_PGA_UP   = 3'd3,
        ST_PGA_DOWN = 3'd4,
        ST_NEXT_CH  = 3'd5,
        ST_RUN      = 3'd6
    } state_t;

    // Default thresholds (ADC codes) and start settings
    localparam int c_dc_lo    = 120;
    localparam int c_dc_hi    = 135;
    localparam int c_clip_lo  = 10;
    localparam int c_clip_hi  = 245;
    localparam int c_dc_init  = 110;
    localparam int c_pga_init = 7;

endpackage : ppg_calib_pkg

`default_nettype wire

// File: rtl/ppg_calib_ctrl_window_stats.sv
// ============================================================================
// Module      : ppg_window_stats
// Description : Windowed min/max statistics over WIN_LEN valid ADC samples.
//               Produces a one-cycle win_done strobe on the last sample of a
//               window together with the midpoint and clip flag of that
//               window (the final sample included).
//               Optional macro PPG_CALIB_SETTLE_EN: discard SETTLE valid
//               samples at the start of every window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ppg_window_stats
    import ppg_calib_pkg::*;
#(
    parameter int ADC_W   = 8,
    parameter int WIN_LEN = 1000,
    parameter int CLIP_LO = c_clip_lo,
    parameter int CLIP_HI = c_clip_hi,
    parameter int SETTLE  = 16
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             clear,
    input  logic [ADC_W-1:0] adc,
    input  logic             adc_valid,
    output logic             win_done,
    output logic [ADC_W:0]   midpoint,
    output logic             clip
);

    localparam int                 c_cnt_w    = (WIN_LEN < 2) ? 1 : $clog2(WIN_LEN);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIN_LEN - 1);
    localparam logic [ADC_W-1:0]   c_lim_lo   = ADC_W'(CLIP_LO);
    localparam logic [ADC_W-1:0]   c_lim_hi   = ADC_W'(CLIP_HI);

    logic [c_cnt_w-1:0] r_cnt;
    logic [ADC_W-1:0]   r_min;
    logic [ADC_W-1:0]   r_max;
    logic               w_take;
    logic [ADC_W-1:0]   w_min;
    logic [ADC_W-1:0]   w_max;

`ifdef PPG_CALIB_SETTLE_EN
    localparam int                 c_set_w    = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [c_set_w-1:0] c_set_load = c_set_w'(SETTLE);

    logic [c_set_w-1:0] r_settle;

    // Every window restart follows a setting change: reload the discard count
    always_ff @(posedge CLK) begin
        if (rst || clear || win_done) begin
            r_settle <= c_set_load;
        end else if (adc_valid && (r_settle != '0)) begin
            r_settle <= r_settle - c_set_w'(1);
        end
    end

    assign w_take = adc_valid && !clear && (r_settle == '0);
`else
    assign w_take = adc_valid && !clear;
`endif

    // Statistics including the current sample, so the decision can be made
    // on the edge that closes the window
    assign w_min    = (adc < r_min) ? adc : r_min;
    assign w_max    = (adc > r_max) ? adc : r_max;
    assign win_done = w_take && (r_cnt == c_cnt_last);
    assign midpoint = ({1'b0, w_max} + {1'b0, w_min}) >> 1;
    assign clip     = (w_min <= c_lim_lo) || (w_max >= c_lim_hi);

    // Sample counter and running extremes, cleared at every window start
    always_ff @(posedge CLK) begin
        if (rst || clear || win_done) begin
            r_cnt <= '0;
            r_min <= '1;
            r_max <= '0;
        end else if (w_take) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
            r_min <= w_min;
            r_max <= w_max;
        end
    end

endmodule : ppg_window_stats

`default_nettype wire

// File: rtl/ppg_calib_ctrl.sv
// ============================================================================
// Module      : ppg_calib_ctrl
// Description : Multi-channel PPG calibration and sequencing controller.
//               Calibrates DC-compensation code and PGA gain per LED channel
//               from windowed ADC statistics, then time-multiplexes the
//               channels round-robin and publishes one sample per slot.
//               Optional macro PPG_CALIB_SETTLE_EN: discard SETTLE samples
//               after each setting change; in RUN, sampling is suppressed
//               when SLOT_LEN <= SETTLE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ppg_calib_ctrl
    import ppg_calib_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int ADC_W    = 8,
    parameter int DC_W     = 7,
    parameter int PGA_W    = 4,
    parameter int WIN_LEN  = 1000,
    parameter int DC_INIT  = c_dc_init,
    parameter int PGA_INIT = c_pga_init,
    parameter int DC_LO    = c_dc_lo,
    parameter int DC_HI    = c_dc_hi,
    parameter int CLIP_LO  = c_clip_lo,
    parameter int CLIP_HI  = c_clip_hi,
    parameter int SLOT_LEN = 10,
    parameter int SETTLE   = 16
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic [ADC_W-1:0]          adc,
    input  logic                      adc_valid,
    input  logic                      find_setting,
    output logic [N_CH-1:0]           led_en,
    output logic [DC_W-1:0]           dc_comp,
    output logic [PGA_W-1:0]          pga_gain,
    output logic                      busy,
    output logic                      done,
    output logic [N_CH-1:0]           fail,
    output logic [N_CH*ADC_W-1:0]     ch_value,
    output logic                      ch_valid,
    output logic [$clog2(N_CH)-1:0]   ch_idx
);

    localparam int                  c_ch_w      = $clog2(N_CH);
    localparam int                  c_slot_w    = (SLOT_LEN < 2) ? 1 : $clog2(SLOT_LEN);
    localparam logic [c_ch_w-1:0]   c_last_ch   = c_ch_w'(N_CH - 1);
    localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(SLOT_LEN - 1);
    localparam logic [N_CH-1:0]     c_led_one   = N_CH'(1);
    localparam logic [DC_W-1:0]     c_dc_init_v = DC_W'(DC_INIT);
    localparam logic [DC_W-1:0]     c_dc_max    = '1;
    localparam logic [DC_W-1:0]     c_dc_one    = DC_W'(1);
    localparam logic [PGA_W-1:0]    c_pga_init_v = PGA_W'(PGA_INIT);
    localparam logic [PGA_W-1:0]    c_pga_max   = '1;
    localparam logic [PGA_W-1:0]    c_pga_one   = PGA_W'(1);
    localparam logic [ADC_W:0]      c_band_lo   = (ADC_W + 1)'(DC_LO);
    localparam logic [ADC_W:0]      c_band_hi   = (ADC_W + 1)'(DC_HI);

`ifdef PPG_CALIB_SETTLE_EN
    localparam logic c_run_sample = (SLOT_LEN > SETTLE);
`else
    localparam logic c_run_sample = 1'b1;
`endif

    state_t                  r_state, w_state;
    logic [c_ch_w-1:0]       r_ch, w_ch;
    logic [DC_W-1:0]         r_dc, w_dc;
    logic [PGA_W-1:0]        r_pga, w_pga;
    logic [N_CH-1:0]         r_led, w_led;
    logic                    r_busy, w_busy;
    logic                    r_done, w_done;
    logic [N_CH-1:0]         r_fail, w_fail;
    logic [DC_W-1:0]         r_dc_mem  [N_CH];
    logic [DC_W-1:0]         w_dc_mem  [N_CH];
    logic [PGA_W-1:0]        r_pga_mem [N_CH];
    logic [PGA_W-1:0]        w_pga_mem [N_CH];
    logic [c_ch_w-1:0]       r_slot, w_slot;
    logic [c_slot_w-1:0]     r_slot_cnt, w_slot_cnt;
    logic [N_CH*ADC_W-1:0]   r_ch_value, w_ch_value;
    logic                    r_ch_valid, w_ch_valid;
    logic [c_ch_w-1:0]       r_ch_idx, w_ch_idx;

    logic                    w_measuring;
    logic                    w_stats_clear;
    logic                    w_win_done;
    logic [ADC_W:0]          w_mid;
    logic                    w_clip;

    // Statistics only accumulate while a calibration window is open
    assign w_measuring   = (r_state == ST_DC_CAL) || (r_state == ST_PGA_DIR) ||
                           (r_state == ST_PGA_UP) || (r_state == ST_PGA_DOWN);
    assign w_stats_clear = find_setting || !w_measuring;

    ppg_window_stats #(
        .ADC_W   (ADC_W),
        .WIN_LEN (WIN_LEN),
        .CLIP_LO (CLIP_LO),
        .CLIP_HI (CLIP_HI),
        .SETTLE  (SETTLE)
    ) u_stats (
        .CLK       (CLK),
        .rst       (rst),
        .clear     (w_stats_clear),
        .adc       (adc),
        .adc_valid (adc_valid),
        .win_done  (w_win_done),
        .midpoint  (w_mid),
        .clip      (w_clip)
    );

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ch       <= '0;
            r_dc       <= c_dc_init_v;
            r_pga      <= '0;
            r_led      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fail     <= '0;
            r_slot     <= '0;
            r_slot_cnt <= '0;
            r_ch_value <= '0;
            r_ch_valid <= 1'b0;
            r_ch_idx   <= '0;
            for (int k = 0; k < N_CH; k++) begin
                r_dc_mem[k]  <= c_dc_init_v;
                r_pga_mem[k] <= '0;
            end
        end else begin
            r_state    <= w_state;
            r_ch       <= w_ch;
            r_dc       <= w_dc;
            r_pga      <= w_pga;
            r_led      <= w_led;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_fail     <= w_fail;
            r_slot     <= w_slot;
            r_slot_cnt <= w_slot_cnt;
            r_ch_value <= w_ch_value;
            r_ch_valid <= w_ch_valid;
            r_ch_idx   <= w_ch_idx;
            r_dc_mem   <= w_dc_mem;
            r_pga_mem  <= w_pga_mem;
        end
    end

    // Next-state and next-output logic; find_setting overrides everything
    always_comb begin
        w_state    = r_state;
        w_ch       = r_ch;
        w_dc       = r_dc;
        w_pga      = r_pga;
        w_led      = r_led;
        w_busy     = r_busy;
        w_done     = r_done;
        w_fail     = r_fail;
        w_slot     = r_slot;
        w_slot_cnt = r_slot_cnt;
        w_ch_value = r_ch_value;
        w_ch_valid = 1'b0;
        w_ch_idx   = r_ch_idx;
        w_dc_mem   = r_dc_mem;
        w_pga_mem  = r_pga_mem;

        if (find_setting) begin
            w_state    = ST_DC_CAL;
            w_ch       = '0;
            w_dc       = c_dc_init_v;
            w_pga      = '0;
            w_led      = c_led_one;
            w_busy     = 1'b1;
            w_done     = 1'b0;
            w_fail     = '0;
            w_slot     = '0;
            w_slot_cnt = '0;
        end else begin
            case (r_state)
                ST_DC_CAL: begin
                    if (w_win_done) begin
                        if ((w_mid < c_band_lo) && (r_dc != '0)) begin
                            w_dc = r_dc - c_dc_one;
                        end else if ((w_mid > c_band_hi) && (r_dc != c_dc_max)) begin
                            w_dc = r_dc + c_dc_one;
                        end else begin
                            // In band, or the required step would wrap the code
                            if ((w_mid < c_band_lo) || (w_mid > c_band_hi)) begin
                                w_fail[r_ch] = 1'b1;
                            end
                            w_dc_mem[r_ch] = r_dc;
                            w_pga          = c_pga_init_v;
                            w_state        = ST_PGA_DIR;
                        end
                    end
                end

                ST_PGA_DIR: begin
                    if (w_win_done) begin
                        if (!w_clip) begin
                            if (r_pga == c_pga_max) begin
                                w_pga_mem[r_ch] = r_pga;
                                w_state         = ST_NEXT_CH;
                            end else begin
                                w_pga   = r_pga + c_pga_one;
                                w_state = ST_PGA_UP;
                            end
                        end else begin
                            if (r_pga == '0) begin
                                w_fail[r_ch]    = 1'b1;
                                w_pga_mem[r_ch] = '0;
                                w_state         = ST_NEXT_CH;
                            end else begin
                                w_pga   = r_pga - c_pga_one;
                                w_state = ST_PGA_DOWN;
                            end
                        end
                    end
                end

                ST_PGA_UP: begin
                    if (w_win_done) begin
                        if (w_clip) begin
                            w_pga           = r_pga - c_pga_one;
                            w_pga_mem[r_ch] = r_pga - c_pga_one;
                            w_state         = ST_NEXT_CH;
                        end else if (r_pga == c_pga_max) begin
                            w_pga_mem[r_ch] = r_pga;
                            w_state         = ST_NEXT_CH;
                        end else begin
                            w_pga = r_pga + c_pga_one;
                        end
                    end
                end

                ST_PGA_DOWN: begin
                    if (w_win_done) begin
                        if (!w_clip) begin
                            w_pga_mem[r_ch] = r_pga;
                            w_state         = ST_NEXT_CH;
                        end else if (r_pga == '0) begin
                            w_fail[r_ch]    = 1'b1;
                            w_pga_mem[r_ch] = '0;
                            w_state         = ST_NEXT_CH;
                        end else begin
                            w_pga = r_pga - c_pga_one;
                        end
                    end
                end

                ST_NEXT_CH: begin
                    if (r_ch == c_last_ch) begin
                        w_state    = ST_RUN;
                        w_busy     = 1'b0;
                        w_done     = 1'b1;
                        w_slot     = '0;
                        w_slot_cnt = '0;
                        w_led      = c_led_one;
                        w_dc       = r_dc_mem[0];
                        w_pga      = r_pga_mem[0];
                    end else begin
                        w_ch    = r_ch + c_ch_w'(1);
                        w_dc    = c_dc_init_v;
                        w_pga   = '0;
                        w_led   = c_led_one << w_ch;
                        w_state = ST_DC_CAL;
                    end
                end

                ST_RUN: begin
                    if (r_slot_cnt == c_slot_last) begin
                        if (adc_valid && c_run_sample) begin
                            w_ch_value[int'(r_slot) * ADC_W +: ADC_W] = adc;
                            w_ch_valid = 1'b1;
                            w_ch_idx   = r_slot;
                        end
                        w_slot     = (r_slot == c_last_ch) ? '0 : r_slot + c_ch_w'(1);
                        w_slot_cnt = '0;
                        w_led      = c_led_one << w_slot;
                        w_dc       = r_dc_mem[w_slot];
                        w_pga      = r_pga_mem[w_slot];
                    end else begin
                        w_slot_cnt = r_slot_cnt + c_slot_w'(1);
                    end
                end

                default: begin
                    w_led = '0;
                end
            endcase
        end
    end

    assign led_en   = r_led;
    assign dc_comp  = r_dc;
    assign pga_gain = r_pga;
    assign busy     = r_busy;
    assign done     = r_done;
    assign fail     = r_fail;
    assign ch_value = r_ch_value;
    assign ch_valid = r_ch_valid;
    assign ch_idx   = r_ch_idx;

endmodule : ppg_calib_ctrl

`default_nettype wire

// File: tb/tb_ppg_calib_ctrl.sv
// ============================================================================
// Module      : tb_ppg_calib_ctrl
// Description : Directed self-checking bench for ppg_calib_ctrl (3 channels,
//               4-sample windows). A small front-end model turns the DUT's
//               LED/DC/PGA settings into ADC samples:
//                 ch0: output stuck at 0 (DC code saturates, gain floor clips)
//                 ch1: midpoint 100 + 4*(110-dc), swing +/-11*pga
//                 ch2: midpoint 128, swing +/-20*pga
//               Honours PPG_CALIB_SETTLE_EN for the first-window timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ppg_calib_ctrl;

`ifdef PPG_CALIB_SETTLE_EN
    localparam int SKIP = 3;
`else
    localparam int SKIP = 0;
`endif

    logic        CLK = 1'b0;
    logic        rst;
    logic [7:0]  adc;
    logic        adc_valid;
    logic        find_setting;
    logic [2:0]  led_en;
    logic [6:0]  dc_comp;
    logic [3:0]  pga_gain;
    logic        busy;
    logic        done;
    logic [2:0]  fail;
    logic [23:0] ch_value;
    logic        ch_valid;
    logic [1:0]  ch_idx;

    int  checks = 0;
    int  errors = 0;
    int  vcnt   = 0;
    int  n;
    bit  auto_valid = 1'b0;
    bit  run_mode   = 1'b0;
    bit  phase      = 1'b0;
    int  m_mid, m_swing, m_val;
    int  exp_dc  [3] = '{0, 105, 110};
    int  exp_pga [3] = '{0, 9, 5};
    logic [7:0] fld;

    ppg_calib_ctrl #(
        .N_CH     (3),
        .ADC_W    (8),
        .DC_W     (7),
        .PGA_W    (4),
        .WIN_LEN  (4),
        .SLOT_LEN (10),
        .SETTLE   (3)
    ) dut (
        .CLK          (CLK),
        .rst          (rst),
        .adc          (adc),
        .adc_valid    (adc_valid),
        .find_setting (find_setting),
        .led_en       (led_en),
        .dc_comp      (dc_comp),
        .pga_gain     (pga_gain),
        .busy         (busy),
        .done         (done),
        .fail         (fail),
        .ch_value     (ch_value),
        .ch_valid     (ch_valid),
        .ch_idx       (ch_idx)
    );

    always #5 CLK = ~CLK;

    // Alternate high/low swing excursion on every valid sample
    always @(posedge CLK) begin
        if (adc_valid) phase <= ~phase;
    end

    // Front-end model; invalid cycles carry 0 so counting them would show
    always_comb begin
        m_mid   = 0;
        m_swing = 0;
        m_val   = 0;
        if (run_mode) begin
            m_val = 160 + ((led_en == 3'b010) ? 1 : (led_en == 3'b100) ? 2 : 0);
        end else begin
            case (led_en)
                3'b010: begin
                    m_mid   = 100 + (110 - int'(dc_comp)) * 4;
                    m_swing = int'(pga_gain) * 11;
                end
                3'b100: begin
                    m_mid   = 128;
                    m_swing = int'(pga_gain) * 20;
                end
                default: begin
                    m_mid   = 0;
                    m_swing = 0;
                end
            endcase
            m_val = phase ? (m_mid + m_swing) : (m_mid - m_swing);
        end
        if (m_val < 0)   m_val = 0;
        if (m_val > 255) m_val = 255;
        if (!adc_valid)  m_val = 0;
        adc = m_val[7:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        vcnt++;
        if (auto_valid) adc_valid = ((vcnt % 3) != 2);
    endtask

    task automatic chk_reset_values(input string pfx);
        chk({pfx, "_led_en"},   32'(led_en),   32'd0);
        chk({pfx, "_dc_comp"},  32'(dc_comp),  32'd110);
        chk({pfx, "_pga_gain"}, 32'(pga_gain), 32'd0);
        chk({pfx, "_busy"},     32'(busy),     32'd0);
        chk({pfx, "_done"},     32'(done),     32'd0);
        chk({pfx, "_fail"},     32'(fail),     32'd0);
        chk({pfx, "_ch_value"}, 32'(ch_value), 32'd0);
        chk({pfx, "_ch_valid"}, 32'(ch_valid), 32'd0);
        chk({pfx, "_ch_idx"},   32'(ch_idx),   32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        adc_valid    = 1'b0;
        find_setting = 1'b0;
        tick();
        tick();
        chk_reset_values("reset");
        rst = 1'b0;
        tick();
        chk("idle_led_off", 32'(led_en), 32'd0);

        // Start calibration from IDLE
        find_setting = 1'b1;
        tick();
        find_setting = 1'b0;
        chk("start_busy", 32'(busy),     32'd1);
        chk("start_led",  32'(led_en),   32'd1);
        chk("start_dc",   32'(dc_comp),  32'd110);
        chk("start_pga",  32'(pga_gain), 32'd0);

        // First window: the change appears right after the last counted sample
        adc_valid = 1'b1;
        for (int i = 0; i < SKIP + 3; i++) tick();
        chk("win_3_samples_dc", 32'(dc_comp), 32'd110);
        adc_valid = 1'b0;
        tick();
        chk("win_invalid_ignored_dc", 32'(dc_comp), 32'd110);
        adc_valid = 1'b1;
        tick();
        chk("win_end_dc_step", 32'(dc_comp), 32'd109);

        // Let channel 0 saturate and fail, then reach channel 1
        auto_valid = 1'b1;
        n = 0;
        while (!(led_en == 3'b010) && n < 3000) begin tick(); n++; end
        chk("wait_ch1", 32'(led_en == 3'b010), 32'd1);
        chk("ch0_fail_flag", 32'(fail), 32'd1);
        chk("ch1_dc_init", 32'(dc_comp), 32'd110);
        chk("ch1_pga_zero", 32'(pga_gain), 32'd0);

        // Channel 1 enters PGA_UP at gain 8; restart there
        n = 0;
        while (!(led_en == 3'b010 && pga_gain == 4'd8) && n < 500) begin tick(); n++; end
        chk("wait_ch1_pga_up", 32'(led_en == 3'b010 && pga_gain == 4'd8), 32'd1);
        chk("ch1_dc_stored_live", 32'(dc_comp), 32'd105);
        find_setting = 1'b1;
        tick();
        find_setting = 1'b0;
        chk("restart_busy", 32'(busy),     32'd1);
        chk("restart_done", 32'(done),     32'd0);
        chk("restart_led",  32'(led_en),   32'd1);
        chk("restart_dc",   32'(dc_comp),  32'd110);
        chk("restart_pga",  32'(pga_gain), 32'd0);
        chk("restart_fail", 32'(fail),     32'd0);

        // Full second calibration through to RUN
        n = 0;
        while (!done && n < 5000) begin tick(); n++; end
        chk("wait_done", 32'(done), 32'd1);
        chk("run_busy",  32'(busy), 32'd0);
        chk("run_fail",  32'(fail), 32'd1);
        chk("run_led0",  32'(led_en),   32'd1);
        chk("run_dc0",   32'(dc_comp),  32'(exp_dc[0]));
        chk("run_pga0",  32'(pga_gain), 32'(exp_pga[0]));

        // Round-robin slots: a sample every 10 cycles, settings of next slot
        auto_valid = 1'b0;
        run_mode   = 1'b1;
        adc_valid  = 1'b1;
        for (int p = 0; p < 4; p++) begin
            n = 0;
            do begin tick(); n++; end while (!ch_valid && n < 20);
            chk("slot_period", 32'(n), 32'd10);
            chk("slot_ch_idx", 32'(ch_idx), 32'(p % 3));
            chk("slot_led",    32'(led_en),   32'(1 << ((p + 1) % 3)));
            chk("slot_dc",     32'(dc_comp),  32'(exp_dc[(p + 1) % 3]));
            chk("slot_pga",    32'(pga_gain), 32'(exp_pga[(p + 1) % 3]));
            fld = ch_value[(p % 3) * 8 +: 8];
            chk("slot_value",  32'(fld), 32'(160 + (p % 3)));
        end
        chk("run_ch_value_all", 32'(ch_value), 32'h00A2A1A0);

        // Synchronous reset in the middle of a calibration window
        run_mode     = 1'b0;
        find_setting = 1'b1;
        tick();
        find_setting = 1'b0;
        tick();
        tick();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk_reset_values("midwin_reset");
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ppg_calib_ctrl

`default_nettype wire
